clock_logic_delay_deskew: RTL and testbench

- Receive-side counterpart of the clock-domain delay chains: takes LANES single-bit lanes that arrive with unequal cycle skew (0..MAX_SKEW) and re-aligns them.
- A training-pulse calibration FSM measures each lane's arrival offset, computes per-lane compensation, then delays every lane so all outputs change in the same cycle.
- Sits in the clock logic group, downstream of any multi-tap delay or multi-path launch logic.

---
 rtl/clock_logic_pkg.sv | 30 +++
 rtl/clock_logic_tap_delay.sv | 49 ++++
 rtl/clock_logic_delay_deskew.sv | 171 +++++++++++++++++
 tb/tb_clock_logic_delay_deskew.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_logic_pkg.sv
// ---------------------------------------------------------------------------
// clock_logic_pkg
// Shared definitions for the clock logic group: calibration FSM state
// encoding and width helpers used to size the deskew datapath and counters.
// ---------------------------------------------------------------------------
package clock_logic_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FIRST = 3'd1,
        MEASURE    = 3'd2,
        COMPUTE    = 3'd3,
        LOCKED     = 3'd4,
        ERROR      = 3'd5
    } cal_state_t;

    // Bits needed to hold a skew/compensation value in 0..max_skew.
    function automatic int skew_width(input int max_skew);
        return (max_skew < 1) ? 1 : $clog2(max_skew + 1);
    endfunction

    // Bits needed for the calibration counter, which must reach both the
    // first-edge timeout and MAX_SKEW+1.
    function automatic int cnt_width(input int max_skew, input int timeout);
        int m;
        m = (timeout > max_skew + 1) ? timeout : max_skew + 1;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/clock_logic_tap_delay.sv
// ---------------------------------------------------------------------------
// clock_logic_tap_delay
// One lane of the deskew datapath: a registered shift line of DEPTH stages
// and a tap mux. Tap k holds d delayed k+1 cycles; q = tap[sel].
// Ports:
//   clock  - rising-edge clock
//   resetn - asynchronous active-low reset (clears the shift line)
//   d      - lane input
//   sel    - tap select (compensation in cycles)
//   q      - selected tap
// ---------------------------------------------------------------------------
module clock_logic_tap_delay
    import clock_logic_pkg::*;
#(
    parameter int DEPTH = 5,
    parameter int DW    = skew_width(DEPTH - 1)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          d,
    input  logic [DW-1:0] sel,
    output logic          q
);

    logic [DEPTH-1:0] line_q;
    logic [DEPTH-1:0] line_d;

    always_comb begin
        line_d = {line_q[DEPTH-2:0], d};
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    // Out-of-range selects (only possible when DEPTH is not a power of two)
    // read as 0 rather than indexing past the line.
    always_comb begin
        q = 1'b0;
        if (int'(sel) < DEPTH) begin
            q = line_q[sel];
        end
    end

endmodule

// File: rtl/clock_logic_delay_deskew.sv
// ---------------------------------------------------------------------------
// clock_logic_delay_deskew
// Re-aligns LANES single-bit lanes that arrive with 0..MAX_SKEW cycles of
// relative skew. A training-pulse calibration measures each lane's arrival
// offset after cal_start; each lane is then delayed by (latest - own) so all
// outputs change in the same cycle.
// Ports:
//   clock, resetn - clock / asynchronous active-low reset
//   cal_start     - single-cycle calibration request
//   data_in       - skewed lanes
//   data_out      - aligned lanes (data_in[i] delayed 1+comp[i] cycles)
//   cal_busy      - calibration in progress
//   cal_done      - last calibration succeeded (level)
//   cal_error     - last calibration failed (level)
//   lane_delay    - applied compensation, lane i at [i*DW +: DW]
// ---------------------------------------------------------------------------
module clock_logic_delay_deskew
    import clock_logic_pkg::*;
#(
    parameter int  LANES       = 4,
    parameter int  MAX_SKEW    = 4,
    parameter int  CAL_TIMEOUT = 15,
    localparam int DW          = skew_width(MAX_SKEW)
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                cal_start,
    input  logic [LANES-1:0]    data_in,
    output logic [LANES-1:0]    data_out,
    output logic                cal_busy,
    output logic                cal_done,
    output logic                cal_error,
    output logic [LANES*DW-1:0] lane_delay
);

    localparam int CW = cnt_width(MAX_SKEW, CAL_TIMEOUT);

    cal_state_t       state_q, state_d;
    logic [LANES-1:0] seen_q, seen_d;
    logic [LANES-1:0] prev_q, prev_d;
    logic [LANES-1:0] edge_w;
    logic [DW-1:0]    arrival_q [LANES];
    logic [DW-1:0]    arrival_d [LANES];
    logic [DW-1:0]    comp_q    [LANES];
    logic [DW-1:0]    comp_d    [LANES];
    logic [CW-1:0]    counter_q, counter_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [DW-1:0]    maxa;

    // prev_q mirrors tap0 of each lane's shift line; a rising edge is a lane
    // that is high now and was low last cycle.
    always_comb begin
        prev_d = data_in;
        edge_w = data_in & ~prev_q;
    end

    always_comb begin
        state_d   = state_q;
        seen_d    = seen_q;
        arrival_d = arrival_q;
        comp_d    = comp_q;
        counter_d = counter_q;
        done_d    = done_q;
        error_d   = error_q;

        maxa = '0;
        for (int i = 0; i < LANES; i++) begin
            if (arrival_q[i] > maxa) maxa = arrival_q[i];
        end

        case (state_q)
            IDLE, LOCKED, ERROR: begin
                if (cal_start) begin
                    state_d   = WAIT_FIRST;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    seen_d    = '0;
                    counter_d = '0;
                end
            end
            WAIT_FIRST: begin
                counter_d = counter_q + 1'b1;
                if (|edge_w) begin
                    // Earliest lane(s) define arrival 0; later lanes are
                    // measured relative to this cycle.
                    seen_d = edge_w;
                    for (int i = 0; i < LANES; i++) begin
                        if (edge_w[i]) arrival_d[i] = '0;
                    end
                    counter_d = CW'(1);
                    state_d   = (&edge_w) ? COMPUTE : MEASURE;
                end else if (counter_q == CW'(CAL_TIMEOUT - 1)) begin
                    state_d = ERROR;
                    error_d = 1'b1;
                end
            end
            MEASURE: begin
                counter_d = counter_q + 1'b1;
                for (int i = 0; i < LANES; i++) begin
                    if (edge_w[i] && !seen_q[i]) begin
                        arrival_d[i] = DW'(counter_q);
                        seen_d[i]    = 1'b1;
                    end
                end
                if (&seen_d) begin
                    state_d = COMPUTE;
                end else if (counter_q == CW'(MAX_SKEW)) begin
                    // Next count would exceed the correctable skew.
                    state_d = ERROR;
                    error_d = 1'b1;
                end
            end
            COMPUTE: begin
                for (int i = 0; i < LANES; i++) begin
                    comp_d[i] = maxa - arrival_q[i];
                end
                done_d  = 1'b1;
                state_d = LOCKED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            seen_q    <= '0;
            prev_q    <= '0;
            counter_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                arrival_q[i] <= '0;
                comp_q[i]    <= '0;
            end
        end else begin
            state_q   <= state_d;
            seen_q    <= seen_d;
            prev_q    <= prev_d;
            counter_q <= counter_d;
            done_q    <= done_d;
            error_q   <= error_d;
            arrival_q <= arrival_d;
            comp_q    <= comp_d;
        end
    end

    // Datapath runs continuously with whatever compensation is current.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        clock_logic_tap_delay #(
            .DEPTH (MAX_SKEW + 1),
            .DW    (DW)
        ) u_tap (
            .clock  (clock),
            .resetn (resetn),
            .d      (data_in[g]),
            .sel    (comp_q[g]),
            .q      (data_out[g])
        );
        assign lane_delay[g*DW +: DW] = comp_q[g];
    end

    assign cal_busy  = (state_q == WAIT_FIRST) || (state_q == MEASURE) ||
                       (state_q == COMPUTE);
    assign cal_done  = done_q;
    assign cal_error = error_q;

endmodule

// File: tb/tb_clock_logic_delay_deskew.sv
// ---------------------------------------------------------------------------
// tb_clock_logic_delay_deskew
// Self-checking bench. A source word is generated each cycle and each lane
// is driven with that word delayed by the lane's skew. Once locked, the
// aligned source word is expected on data_out a fixed latency later; these
// expectations go through a scoreboard queue. Calibration status and
// lane_delay are checked at the cycles where they must change.
// ---------------------------------------------------------------------------
module tb_clock_logic_delay_deskew;

    localparam int LANES       = 4;
    localparam int MAX_SKEW    = 4;
    localparam int CAL_TIMEOUT = 15;
    localparam int DW          = $clog2(MAX_SKEW + 1);
    localparam logic [LANES-1:0] ALL1 = '1;

    logic                clock  = 1'b0;
    logic                resetn = 1'b0;
    logic                cal_start = 1'b0;
    logic [LANES-1:0]    data_in = '0;
    logic [LANES-1:0]    data_out;
    logic                cal_busy;
    logic                cal_done;
    logic                cal_error;
    logic [LANES*DW-1:0] lane_delay;

    clock_logic_delay_deskew #(
        .LANES       (LANES),
        .MAX_SKEW    (MAX_SKEW),
        .CAL_TIMEOUT (CAL_TIMEOUT)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .cal_start  (cal_start),
        .data_in    (data_in),
        .data_out   (data_out),
        .cal_busy   (cal_busy),
        .cal_done   (cal_done),
        .cal_error  (cal_error),
        .lane_delay (lane_delay)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit [LANES-1:0] src_hist [0:4095];
    int             skew [LANES];
    bit             sb_en  = 1'b0;
    int             sb_lat = 1;

    typedef struct {
        int             due;
        logic [LANES-1:0] val;
    } sb_item_t;
    sb_item_t sb_q [$];

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pack4(input int l0, input int l1,
                                          input int l2, input int l3);
        return 32'(l0 | (l1 << DW) | (l2 << (2 * DW)) | (l3 << (3 * DW)));
    endfunction

    task automatic status(input string tag, input bit busy, input bit done,
                          input bit err);
        check_eq({tag, "_busy"},  32'(cal_busy),  32'(busy));
        check_eq({tag, "_done"},  32'(cal_done),  32'(done));
        check_eq({tag, "_error"}, 32'(cal_error), 32'(err));
    endtask

    // One clock: wait for the edge, compare due scoreboard entries, then
    // drive the next skewed input word.
    task automatic step(input bit [LANES-1:0] src);
        sb_item_t it;
        int       idx;
        @(posedge clock);
        #1;
        cyc++;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            it = sb_q.pop_front();
            check_eq("aligned_data", 32'(data_out), 32'(it.val));
        end
        src_hist[cyc] = src;
        for (int i = 0; i < LANES; i++) begin
            idx = cyc - skew[i];
            data_in[i] = (idx >= 0) ? src_hist[idx][i] : 1'b0;
        end
        if (sb_en) begin
            it.due = cyc + sb_lat;
            it.val = src;
            sb_q.push_back(it);
        end
    endtask

    task automatic quiet(input int n);
        repeat (n) step('0);
    endtask

    task automatic cal_pulse();
        cal_start = 1'b1;
        step('0);
        cal_start = 1'b0;
    endtask

    task automatic sb_burst(input int lat, input int n);
        sb_lat = lat;
        sb_en  = 1'b1;
        repeat (n) step(LANES'($urandom));
        step(ALL1);
        repeat (lat) step('0);
        sb_en = 1'b0;
        repeat (12) if (sb_q.size() > 0) step('0);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) src_hist[i] = '0;
        skew = '{0, 0, 0, 0};

        // Reset holds everything at zero regardless of input activity.
        resetn = 1'b0;
        repeat (3) begin
            step(LANES'($urandom));
            check_eq("rst_data_out", 32'(data_out), 32'd0);
            check_eq("rst_lane_delay", 32'(lane_delay), 32'd0);
            status("rst", 1'b0, 1'b0, 1'b0);
        end
        resetn = 1'b1;
        sb_burst(1, 12);

        // All lanes edge together: straight to COMPUTE, zero compensation.
        quiet(4);
        cal_pulse();
        status("sim_accept", 1'b1, 1'b0, 1'b0);
        step(ALL1);
        status("sim_wait", 1'b1, 1'b0, 1'b0);
        step(ALL1);
        status("sim_compute", 1'b1, 1'b0, 1'b0);
        step(ALL1);
        status("sim_locked", 1'b0, 1'b1, 1'b0);
        check_eq("sim_lane_delay", 32'(lane_delay), 32'd0);
        quiet(6);
        sb_burst(1, 10);

        // Staircase skew 0,1,2,3 -> compensation 3,2,1,0, latency 4.
        quiet(6);
        skew = '{0, 1, 2, 3};
        quiet(6);
        cal_pulse();
        status("stair_accept", 1'b1, 1'b0, 1'b0);
        repeat (5) step(ALL1);
        status("stair_compute", 1'b1, 1'b0, 1'b0);
        step(ALL1);
        status("stair_locked", 1'b0, 1'b1, 1'b0);
        check_eq("stair_lane_delay", 32'(lane_delay), pack4(3, 2, 1, 0));
        repeat (2) step(ALL1);
        quiet(6);
        sb_burst(4, 16);

        // Lane3 five cycles late: out of range, compensation retained.
        quiet(6);
        skew = '{0, 1, 2, 5};
        quiet(6);
        cal_pulse();
        status("oor_accept", 1'b1, 1'b0, 1'b0);
        repeat (5) step(ALL1);
        status("oor_measure", 1'b1, 1'b0, 1'b0);
        step(ALL1);
        status("oor_error", 1'b0, 1'b0, 1'b1);
        check_eq("oor_lane_delay", 32'(lane_delay), pack4(3, 2, 1, 0));
        repeat (2) step(ALL1);
        quiet(8);

        // No training edge at all: timeout after CAL_TIMEOUT cycles.
        cal_pulse();
        status("to_accept", 1'b1, 1'b0, 1'b0);
        repeat (CAL_TIMEOUT - 1) step('0);
        status("to_wait", 1'b1, 1'b0, 1'b0);
        step('0);
        status("to_error", 1'b0, 1'b0, 1'b1);
        check_eq("to_lane_delay", 32'(lane_delay), pack4(3, 2, 1, 0));

        // New calibration clears the error; cal_start in MEASURE is ignored.
        skew = '{0, 1, 2, 3};
        quiet(6);
        cal_pulse();
        status("re_accept", 1'b1, 1'b0, 1'b0);
        step(ALL1);
        step(ALL1);
        cal_start = 1'b1;
        step(ALL1);
        cal_start = 1'b0;
        status("mid_start", 1'b1, 1'b0, 1'b0);
        step(ALL1);
        step(ALL1);
        status("mid_compute", 1'b1, 1'b0, 1'b0);
        step(ALL1);
        status("mid_locked", 1'b0, 1'b1, 1'b0);
        check_eq("mid_lane_delay", 32'(lane_delay), pack4(3, 2, 1, 0));
        repeat (3) step(ALL1);
        quiet(6);
        sb_burst(4, 8);

        // Reset in the middle of MEASURE abandons calibration.
        quiet(2);
        cal_pulse();
        step(ALL1);
        step(ALL1);
        status("pre_rst", 1'b1, 1'b0, 1'b0);
        resetn = 1'b0;
        #1;
        status("rst_mid", 1'b0, 1'b0, 1'b0);
        check_eq("rst_mid_lane_delay", 32'(lane_delay), 32'd0);
        check_eq("rst_mid_data_out", 32'(data_out), 32'd0);
        step(ALL1);
        resetn = 1'b1;
        quiet(4);
        status("post_rst", 1'b0, 1'b0, 1'b0);
        check_eq("post_rst_lane_delay", 32'(lane_delay), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish (cycle %0d)", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
